alu_exec_unit: RTL



---
 rtl/alu_exec_unit_if.sv | 33 +++
 rtl/alu_exec_unit.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit_if.sv
// alu_exec_unit_if: operand/result handshake bundle for the execute-stage ALU.
//   master: producer side (issue stage / testbench) drives operands and out_ready.
//   slave : the ALU; drives in_ready and the registered result/zero/illegal/out_valid.
// Signals:
//   in_valid, in_ready       - request handshake
//   ALU_control[2:0]         - operation code from the ALU decoder
//   src_a, src_b [WIDTH]     - operands
//   out_valid, out_ready     - response handshake
//   result [WIDTH], zero, illegal - registered response payload
interface alu_exec_unit_if #(
  parameter int unsigned WIDTH = 32
) ();
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       ALU_control;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             illegal;

  modport master (
    output in_valid, ALU_control, src_a, src_b, out_ready,
    input  in_ready, out_valid, result, zero, illegal
  );

  modport slave (
    input  in_valid, ALU_control, src_a, src_b, out_ready,
    output in_ready, out_valid, result, zero, illegal
  );
endinterface

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute-stage ALU with a registered, handshaked result.
//   clk    - core clock, rising edge
//   rst_n  - synchronous active-low reset
//   flush  - squash the held or in-flight operation (branch mispredict)
//   bus    - alu_exec_unit_if.slave: operands/ALU_control in, result/zero/illegal out
// Codes: 000 add, 001 sub, 010 and, 011 or, 101 slt (signed), 100 mul, others illegal.
// Build option: define ALU_MUL_EN to add a shift-add multiplier for code 100
// (WIDTH-cycle latency). Without it, code 100 is reported illegal like 110/111.
module alu_exec_unit #(
  parameter int unsigned WIDTH = 32
) (
  input logic             clk,
  input logic             rst_n,
  input logic             flush,
  alu_exec_unit_if.slave  bus
);

  // StHold means a result is presented (out_valid); StIdle means nothing pending.
`ifdef ALU_MUL_EN
  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  typedef enum logic [1:0] {StIdle, StHold, StBusy} state_e;
`else
  typedef enum logic [0:0] {StIdle, StHold} state_e;
`endif

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             illegal_q, illegal_d;
  logic             out_valid;
  logic             not_busy;
  logic             in_ready;
  logic             accept;
  logic             is_mul;
  logic [WIDTH-1:0] op_res;
  logic             op_ill;

`ifdef ALU_MUL_EN
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] acc_step;

  assign not_busy = (state_q != StBusy);
  assign is_mul   = (bus.ALU_control == 3'b100);
  // One multiplier bit per cycle; the product is taken modulo 2^WIDTH.
  assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
`else
  assign not_busy = 1'b1;
  assign is_mul   = 1'b0;
`endif

  assign out_valid = (state_q == StHold);
  // Gated by rst_n so nothing is advertised while reset is held.
  assign in_ready  = rst_n && not_busy && !flush && (!out_valid || bus.out_ready);
  assign accept    = bus.in_valid && in_ready;

  // Single-cycle operation decode.
  always_comb begin
    op_res = '0;
    op_ill = 1'b0;
    case (bus.ALU_control)
      3'b000:  op_res = bus.src_a + bus.src_b;
      3'b001:  op_res = bus.src_a - bus.src_b;
      3'b010:  op_res = bus.src_a & bus.src_b;
      3'b011:  op_res = bus.src_a | bus.src_b;
      3'b101:  op_res = {{(WIDTH-1){1'b0}}, ($signed(bus.src_a) < $signed(bus.src_b))};
      default: op_ill = 1'b1;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;
`ifdef ALU_MUL_EN
    cnt_d     = cnt_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
`endif
    if (flush) begin
      // Result payload may stay stale; only out_valid and the iteration are killed.
      state_d = StIdle;
`ifdef ALU_MUL_EN
      cnt_d   = '0;
`endif
    end else begin
      case (state_q)
        StIdle, StHold: begin
          if (accept) begin
`ifdef ALU_MUL_EN
            if (is_mul) begin
              state_d  = StBusy;
              cnt_d    = '0;
              acc_d    = '0;
              mcand_d  = bus.src_a;
              mplier_d = bus.src_b;
            end else
`endif
            begin
              state_d   = StHold;
              result_d  = op_res;
              zero_d    = (op_res == '0);
              illegal_d = op_ill;
            end
          end else if ((state_q == StHold) && bus.out_ready) begin
            state_d = StIdle;
          end
        end
`ifdef ALU_MUL_EN
        StBusy: begin
          acc_d    = acc_step;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          if (cnt_q == CntW'(WIDTH - 1)) begin
            state_d   = StHold;
            cnt_d     = '0;
            result_d  = acc_step;
            zero_d    = (acc_step == '0);
            illegal_d = 1'b0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
`endif
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      result_q  <= '0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
`ifdef ALU_MUL_EN
      cnt_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
`ifdef ALU_MUL_EN
      cnt_q     <= cnt_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
`endif
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.illegal   = illegal_q;

endmodule
